// File: rtl/sa_pkg.sv
// sa_pkg: shared defaults for the systolic array (column count, partial-sum
// width, operand width) and width helpers for counters and pointers.
package sa_pkg;

    localparam int SA_N  = 2;   // array columns
    localparam int SA_CW = 9;   // partial-sum width per column
    localparam int SA_DW = 4;   // PE operand width

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer into depth entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// sa_row_fifo: synchronous first-word-fall-through FIFO with registered storage.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous clear of pointers and count (storage kept)
//   push, push_data   write request and row
//   pop               read request; head advances when not empty
//   pop_data          head entry (valid while !empty)
//   full, empty       occupancy flags
//   count             number of stored entries
// A push while full is only accepted together with a pop in the same cycle.
module sa_row_fifo
    import sa_pkg::*;
#(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [W-1:0]                  push_data,
    input  logic                          pop,
    output logic [W-1:0]                  pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int PW   = ptr_width(DEPTH);
    localparam int CNTW = cnt_width(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] cnt;
    logic            wr_en;
    logic            rd_en;

    assign full     = (cnt == CNTW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    assign rd_en = pop && !empty && !clear;
    // When full, the slot being written is the head being popped this edge.
    assign wr_en = push && !clear && (!full || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNTW'(1);
                2'b01:   cnt <= cnt - CNTW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sa_result_collector.sv
// sa_result_collector: bottom-edge drain of the systolic array. Removes the
// one-cycle-per-column skew of the bottom-row cout bus, packs each row into
// one word, buffers rows in a FIFO and returns credits to the controller.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   col_valid_in       column 0 carries a final row result this cycle
//   cout_in            bottom-row cout bus, column j at [j*CW +: CW]
//   flush              synchronous clear of deskew valids and FIFO
//   res_valid/ready    output row handshake
//   res_data           aligned row, column j at [j*CW +: CW]
//   credit             free FIFO slots minus rows in flight (registered)
//   overflow           sticky: a row was dropped
//   row_count          rows popped, wraps
// Handshake: a row transfers on every rising edge where res_valid && res_ready;
// while res_valid=1 and res_ready=0, res_valid and res_data hold steady, and
// res_valid never depends combinationally on res_ready or any input.
module sa_result_collector
    import sa_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int CW    = SA_CW,
    parameter int DEPTH = 4,
    parameter int RCW   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          col_valid_in,
    input  logic [N*CW-1:0]               cout_in,
    input  logic                          flush,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [N*CW-1:0]               res_data,
    output logic [cnt_width(DEPTH)-1:0]   credit,
    output logic                          overflow,
    output logic [RCW-1:0]                row_count
);

    localparam int CRW = cnt_width(DEPTH);

    logic [N*CW-1:0] aligned;
    logic            push_row;      // aligned row present at this edge
    logic            push_req;
    logic            push_acc;
    logic            pop_fire;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CRW-1:0]  fifo_count;
    int              inflight_next; // rows in the valid delay line after this edge
    int              cnt_next;
    int              free_next;

    // Valid delay line: column 0 launches, the row is complete N-1 cycles later.
    if (N > 1) begin : g_vline
        logic [N-2:0] vline;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vline <= '0;
            end else if (flush) begin
                vline <= '0;
            end else begin
                vline[0] <= col_valid_in;
                for (int k = 1; k < N - 1; k++) vline[k] <= vline[k-1];
            end
        end

        assign push_row = vline[N-2];

        // Population of the next delay-line state; the last stage leaves it.
        always_comb begin
            inflight_next = 0;
            if (!flush) begin
                inflight_next = int'(col_valid_in);
                for (int k = 0; k < N - 2; k++) inflight_next += int'(vline[k]);
            end
        end
    end else begin : g_no_vline
        assign push_row      = col_valid_in;
        assign inflight_next = 0;
    end

    // Column j arrives j cycles after launch; delay it N-1-j cycles to align.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned[j*CW +: CW] = cout_in[j*CW +: CW];
        end else begin : g_dly
            logic [CW-1:0] sr [D];
            always_ff @(posedge clk) begin
                sr[0] <= cout_in[j*CW +: CW];
                for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
            end
            assign aligned[j*CW +: CW] = sr[D-1];
        end
    end

    assign res_valid = !fifo_empty;
    assign pop_fire  = res_valid && res_ready && !flush;
    assign push_req  = push_row && !flush;
    assign push_acc  = push_req && (!fifo_full || pop_fire);
    assign drop      = push_req && fifo_full && !pop_fire;

    sa_row_fifo #(
        .W     (N*CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push_req),
        .push_data (aligned),
        .pop       (pop_fire),
        .pop_data  (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Credit is computed from the post-edge state so it is current the cycle
    // after any launch, push or pop.
    always_comb begin
        cnt_next = int'(fifo_count);
        if (push_acc) cnt_next = cnt_next + 1;
        if (pop_fire) cnt_next = cnt_next - 1;
        if (flush)    cnt_next = 0;
        free_next = DEPTH - cnt_next - inflight_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit    <= CRW'(DEPTH);
            overflow  <= 1'b0;
            row_count <= '0;
        end else begin
            credit <= (free_next > 0) ? CRW'(free_next) : '0;
            if (flush) begin
                overflow <= 1'b0;
            end else begin
                if (drop)     overflow  <= 1'b1;
                if (pop_fire) row_count <= row_count + RCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sa_result_collector.sv
module tb_sa_result_collector;

    localparam int N     = 2;
    localparam int CW    = 9;
    localparam int DEPTH = 4;
    localparam int RCW   = 8;
    localparam int W     = N * CW;

    logic          clk;
    logic          rst;
    logic          col_valid_in;
    logic [W-1:0]  cout_in;
    logic          flush;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [2:0]    credit;
    logic          overflow;
    logic [RCW-1:0] row_count;

    int n_checks = 0;
    int n_errors = 0;

    sa_result_collector #(
        .N(N), .CW(CW), .DEPTH(DEPTH), .RCW(RCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col_valid_in (col_valid_in),
        .cout_in      (cout_in),
        .flush        (flush),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .credit       (credit),
        .overflow     (overflow),
        .row_count    (row_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         cv;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
        logic         rdy;
        logic         fl;
        logic         ev;
        logic [W-1:0] ed;
        int           ecr;
        logic         eov;
        int           erc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [W-1:0] rowv(input int hi, input int lo);
        logic [W-1:0] r;
        r = {CW'(hi), CW'(lo)};
        return r;
    endfunction

    task automatic add(input logic cv, input int c0, input int c1, input logic rdy,
                       input logic fl, input logic ev, input logic [W-1:0] ed,
                       input int ecr, input logic eov, input int erc);
        vec_t v;
        v.cv = cv; v.c0 = CW'(c0); v.c1 = CW'(c1); v.rdy = rdy; v.fl = fl;
        v.ev = ev; v.ed = ed; v.ecr = ecr; v.eov = eov; v.erc = erc;
        tbl.push_back(v);
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0] exp_q[$];     // rows held downstream, head first
    int           pend[$];      // launch cycles of rows still being deskewed
    logic [W-1:0] hist [64];    // cout_in seen per cycle (mod 64)
    int           m_credit;
    logic         m_ov;
    logic [RCW-1:0] m_rc;

    initial begin
        rst = 1'b1; col_valid_in = 1'b0; cout_in = '0; flush = 1'b0; res_ready = 1'b0;
        repeat (3) next_cycle();
        chk("reset_valid", 32'(res_valid), 0);
        chk("reset_credit", 32'(credit), 4);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_row_count", 32'(row_count), 0);
        rst = 1'b0;
        next_cycle();

        // single row {40,25}
        add(1, 25, 0, 1, 0,  0, '0, 4, 0, 0);
        add(0, 0, 40, 1, 0,  0, '0, 3, 0, 0);
        add(0, 0, 0, 1, 0,   1, rowv(40, 25), 3, 0, 0);
        add(0, 0, 0, 0, 0,   0, '0, 4, 0, 1);
        // fill 1..4, overflow with 7, drain, then flush clears overflow
        add(1, 1, 0, 0, 0,   0, '0, 4, 0, 1);
        add(1, 2, 1, 0, 0,   0, '0, 3, 0, 1);
        add(1, 3, 2, 0, 0,   1, rowv(1, 1), 2, 0, 1);
        add(1, 4, 3, 0, 0,   1, rowv(1, 1), 1, 0, 1);
        add(1, 7, 4, 0, 0,   1, rowv(1, 1), 0, 0, 1);
        add(0, 0, 7, 0, 0,   1, rowv(1, 1), 0, 0, 1);
        add(0, 0, 0, 0, 0,   1, rowv(1, 1), 0, 1, 1);
        add(0, 0, 0, 1, 0,   1, rowv(1, 1), 0, 1, 1);
        add(0, 0, 0, 1, 0,   1, rowv(2, 2), 1, 1, 2);
        add(0, 0, 0, 1, 0,   1, rowv(3, 3), 2, 1, 3);
        add(0, 0, 0, 1, 0,   1, rowv(4, 4), 3, 1, 4);
        add(0, 0, 0, 1, 1,   0, '0, 4, 1, 5);
        // push arrives while full in the same cycle the head pops
        add(1, 8, 0, 0, 0,   0, '0, 4, 0, 5);
        add(1, 9, 8, 0, 0,   0, '0, 3, 0, 5);
        add(1, 10, 9, 0, 0,  1, rowv(8, 8), 2, 0, 5);
        add(1, 11, 10, 0, 0, 1, rowv(8, 8), 1, 0, 5);
        add(1, 12, 11, 0, 0, 1, rowv(8, 8), 0, 0, 5);
        add(0, 0, 12, 1, 0,  1, rowv(8, 8), 0, 0, 5);
        add(0, 0, 0, 0, 0,   1, rowv(9, 9), 0, 0, 6);
        add(0, 0, 0, 1, 0,   1, rowv(9, 9), 0, 0, 6);
        add(0, 0, 0, 1, 0,   1, rowv(10, 10), 1, 0, 7);
        add(0, 0, 0, 1, 0,   1, rowv(11, 11), 2, 0, 8);
        add(0, 0, 0, 1, 0,   1, rowv(12, 12), 3, 0, 9);
        add(0, 0, 0, 0, 0,   0, '0, 4, 0, 10);
        // flush mid-flight, with a launch in the flush cycle
        add(1, 5, 0, 1, 0,   0, '0, 4, 0, 10);
        add(1, 9, 6, 1, 1,   0, '0, 3, 0, 10);
        add(0, 0, 0, 1, 0,   0, '0, 4, 0, 10);
        add(0, 0, 0, 1, 0,   0, '0, 4, 0, 10);
        add(0, 0, 0, 1, 0,   0, '0, 4, 0, 10);
        // flush while a pop is offered: pop ignored
        add(1, 3, 0, 0, 0,   0, '0, 4, 0, 10);
        add(0, 0, 3, 0, 0,   0, '0, 3, 0, 10);
        add(0, 0, 0, 1, 1,   1, rowv(3, 3), 3, 0, 10);
        add(0, 0, 0, 1, 0,   0, '0, 4, 0, 10);
        add(0, 0, 0, 1, 0,   0, '0, 4, 0, 10);

        for (int i = 0; i < tbl.size(); i++) begin
            col_valid_in = tbl[i].cv;
            cout_in      = {tbl[i].c1, tbl[i].c0};
            res_ready    = tbl[i].rdy;
            flush        = tbl[i].fl;
            chk($sformatf("vec%0d_valid", i), 32'(res_valid), 32'(tbl[i].ev));
            if (tbl[i].ev)
                chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_credit", i), 32'(credit), 32'(tbl[i].ecr));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].eov));
            chk($sformatf("vec%0d_row_count", i), 32'(row_count), 32'(tbl[i].erc));
            next_cycle();
        end

        // async reset mid-cycle with one row queued and one in flight
        col_valid_in = 1'b1; cout_in = {CW'(0), CW'(21)}; res_ready = 1'b0; flush = 1'b0;
        next_cycle();
        cout_in = {CW'(22), CW'(30)};
        next_cycle();
        col_valid_in = 1'b0; cout_in = {CW'(31), CW'(0)};
        chk("pre_reset_valid", 32'(res_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(res_valid), 0);
        chk("async_reset_credit", 32'(credit), 4);
        chk("async_reset_overflow", 32'(overflow), 0);
        chk("async_reset_row_count", 32'(row_count), 0);
        next_cycle();
        rst = 1'b0; res_ready = 1'b1; cout_in = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_reset%0d_valid", i), 32'(res_valid), 0);
            chk($sformatf("post_reset%0d_credit", i), 32'(credit), 4);
            next_cycle();
        end

        // randomized traffic against the queue model
        exp_q.delete(); pend.delete();
        m_credit = DEPTH; m_ov = 1'b0; m_rc = '0;
        for (int c = 0; c < 1500; c++) begin
            logic [W-1:0] row;
            logic pop;
            col_valid_in = (m_credit > 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 15);
            cout_in      = W'($urandom);
            res_ready    = ($urandom_range(0, 99) < 60);
            flush        = ($urandom_range(0, 99) < 2);
            hist[c % 64] = cout_in;

            chk($sformatf("rnd%0d_valid", c), 32'(res_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0 && res_valid)
                chk($sformatf("rnd%0d_data", c), 32'(res_data), 32'(exp_q[0]));
            chk($sformatf("rnd%0d_credit", c), 32'(credit), 32'(m_credit));
            chk($sformatf("rnd%0d_overflow", c), 32'(overflow), 32'(m_ov));
            chk($sformatf("rnd%0d_row_count", c), 32'(row_count), 32'(m_rc));

            if (flush) begin
                exp_q.delete();
                pend.delete();
                m_ov = 1'b0;
            end else begin
                pop = res_ready && (exp_q.size() > 0);
                if (pop) begin
                    void'(exp_q.pop_front());
                    m_rc = m_rc + 1'b1;
                end
                if (col_valid_in) pend.push_back(c);
                if (pend.size() > 0 && pend[0] == c - (N - 1)) begin
                    for (int j = 0; j < N; j++)
                        row[j*CW +: CW] = hist[(pend[0] + j) % 64][j*CW +: CW];
                    void'(pend.pop_front());
                    if (exp_q.size() < DEPTH) exp_q.push_back(row);
                    else m_ov = 1'b1;
                end
            end
            m_credit = DEPTH - exp_q.size() - pend.size();
            if (m_credit < 0) m_credit = 0;
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
